// File: rtl/trivium_stream_w.sv
// Trivium stream cipher producing W keystream bits per clock and XORing them onto
// a valid/ready word stream; parallel key/IV load, warm-up, and a per-key word limit.
module trivium_stream_w #(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = 1152,
    parameter int MAX_WORDS   = 2**20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [79:0]   key_in,
    input  logic [79:0]   iv_in,
    input  logic          load,
    input  logic [W-1:0]  din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [W-1:0]  dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy,
    output logic          exhausted
);

    localparam int INIT_CYCLES = INIT_ROUNDS / W;
    localparam int IW = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
    localparam int CW = (MAX_WORDS < 1) ? 1 : $clog2(MAX_WORDS + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [IW-1:0] INIT_END  = IW'(INIT_CYCLES);
    localparam logic [CW-1:0] WORD_LAST = CW'(MAX_WORDS - 1);
    localparam logic [CW-1:0] WORD_END  = CW'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, INIT, RUN, EXHAUSTED} state_t;

    state_t         state;
    logic [287:0]   cs;
    logic [287:0]   cs_next;
    logic [287:0]   s;
    logic [W-1:0]   z;
    logic           t1, t2, t3, a1, a2, a3;
    logic [IW-1:0]  init_cnt;
    logic [CW-1:0]  word_cnt;
    logic           handshake;

    // cs[i-1] holds Trivium bit s_i; W update steps are unrolled, z[0] is the earliest bit
    always_comb begin
        s  = cs;
        z  = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        a1 = 1'b0;
        a2 = 1'b0;
        a3 = 1'b0;
        for (int i = 0; i < W; i++) begin
            t1   = s[65]  ^ s[92];
            t2   = s[161] ^ s[176];
            t3   = s[242] ^ s[287];
            z[i] = t1 ^ t2 ^ t3;
            a1   = t1 ^ (s[90]  & s[91])  ^ s[170];
            a2   = t2 ^ (s[174] & s[175]) ^ s[263];
            a3   = t3 ^ (s[285] & s[286]) ^ s[68];
            s    = {s[286:177], a2, s[175:93], a1, s[91:0], a3};
        end
        cs_next = s;
    end

    assign din_ready = (state == RUN) && (!dout_valid || dout_ready) && !load;
    assign handshake = din_valid && din_ready;

    // load overrides everything, even mid-warm-up or after exhaustion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cs         <= '0;
            init_cnt   <= '0;
            word_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            exhausted  <= 1'b0;
        end else if (load) begin
            state      <= INIT;
            cs         <= {3'b111, 112'b0, iv_in, 13'b0, key_in};
            init_cnt   <= '0;
            word_cnt   <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b1;
            exhausted  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                INIT: begin
                    cs <= cs_next;
                    if (init_cnt != INIT_END) begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                    if (init_cnt >= INIT_LAST) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN, EXHAUSTED: begin
                    if (handshake) begin
                        dout       <= din ^ z;
                        dout_valid <= 1'b1;
                        cs         <= cs_next;
                        if (word_cnt != WORD_END) begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                        if (word_cnt == WORD_LAST) begin
                            state     <= EXHAUSTED;
                            exhausted <= 1'b1;
                        end
                    end else if (dout_ready) begin
                        dout_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_stream_w.sv
// Directed bench for trivium_stream_w: W=8 and W=1 cores against a bit-serial
// Trivium model, plus a MAX_WORDS=4 core for the word-limit behaviour.
module tb_trivium_stream_w;

    typedef logic [4095:0] ks_t;

    localparam logic [79:0] KEY_A = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] KEY_B = 80'hFEDCBA98765432100F1E;
    localparam logic [79:0] KEY_C = 80'h13579BDF02468ACE1122;
    localparam logic [79:0] IV_B  = 80'h00112233445566778899;
    localparam logic [79:0] IV_R  = 80'hA5A500000000000F5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [79:0] key = '0;
    logic [79:0] iv  = '0;

    logic       load8 = 1'b0, dval8 = 1'b0, doutrdy8 = 1'b0;
    logic [7:0] din8 = '0;
    logic       dinrdy8, dvalid8, busy8, exh8;
    logic [7:0] dout8;

    logic       load1 = 1'b0, dval1 = 1'b0, doutrdy1 = 1'b0;
    logic [0:0] din1 = '0;
    logic       dinrdy1, dvalid1, busy1, exh1;
    logic [0:0] dout1;

    logic       loadx = 1'b0, dvalx = 1'b0, doutrdyx = 1'b0;
    logic [7:0] dinx = '0;
    logic       dinrdyx, dvalidx, busyx, exhx;
    logic [7:0] doutx;

    int  n_cmp = 0;
    int  n_err = 0;
    ks_t ks_a, ks_b;

    always #5 clk = ~clk;

    trivium_stream_w #(.W(8), .INIT_ROUNDS(1152)) dut8 (
        .clk(clk), .rst(rst), .key_in(key), .iv_in(iv), .load(load8),
        .din(din8), .din_valid(dval8), .din_ready(dinrdy8),
        .dout(dout8), .dout_valid(dvalid8), .dout_ready(doutrdy8),
        .busy(busy8), .exhausted(exh8));

    trivium_stream_w #(.W(1), .INIT_ROUNDS(1152)) dut1 (
        .clk(clk), .rst(rst), .key_in(key), .iv_in(iv), .load(load1),
        .din(din1), .din_valid(dval1), .din_ready(dinrdy1),
        .dout(dout1), .dout_valid(dvalid1), .dout_ready(doutrdy1),
        .busy(busy1), .exhausted(exh1));

    trivium_stream_w #(.W(8), .INIT_ROUNDS(1152), .MAX_WORDS(4)) dutx (
        .clk(clk), .rst(rst), .key_in(key), .iv_in(iv), .load(loadx),
        .din(dinx), .din_valid(dvalx), .din_ready(dinrdyx),
        .dout(doutx), .dout_valid(dvalidx), .dout_ready(doutrdyx),
        .busy(busyx), .exhausted(exhx));

    // Bit-serial reference: 1152 discarded steps, then ks[k] is keystream bit k
    task automatic model_run(input logic [79:0] k, input logic [79:0] v, output ks_t ks);
        bit ms [1:288];
        bit t1, t2, t3, a1, a2, a3, z;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[i-1];
            ms[93 + i] = v[i-1];
        end
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
        ks = '0;
        for (int n = 0; n < 1152 + 4096; n++) begin
            t1 = ms[66] ^ ms[93];
            t2 = ms[162] ^ ms[177];
            t3 = ms[243] ^ ms[288];
            z  = t1 ^ t2 ^ t3;
            a1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
            a2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
            a3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
            for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
            ms[1] = a3;
            for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
            ms[94] = a1;
            for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
            ms[178] = a2;
            if (n >= 1152) ks[n-1152] = z;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load8(input logic [79:0] k, input logic [79:0] v);
        key = k; iv = v;
        load8 = 1'b1;
        tick();
        load8 = 1'b0;
        repeat (144) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (dinrdy8 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_din_ready: got %b expected 0", dinrdy8); end
        n_cmp++; if (dout8 !== 8'h00) begin n_err++; $display("[TB] FAIL reset_dout: got %h expected 00", dout8); end
        n_cmp++; if (dvalid8 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_dout_valid: got %b expected 0", dvalid8); end
        n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy8); end
        n_cmp++; if (exh8 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_exhausted: got %b expected 0", exh8); end
        rst = 1'b1;
        dval8 = 1'b1;
        repeat (2) tick();
        n_cmp++; if ({busy8, dinrdy8, dvalid8} !== 3'b000) begin n_err++; $display("[TB] FAIL idle_after_reset: got %b expected 000", {busy8, dinrdy8, dvalid8}); end
        dval8 = 1'b0;
    endtask

    task automatic test_warmup();
        int busy_cycles;
        int bad;
        model_run(80'h0, 80'h0, ks_a);
        key = '0; iv = '0; doutrdy8 = 1'b1;
        load8 = 1'b1;
        tick();
        load8 = 1'b0;
        n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("[TB] FAIL busy_after_load: got %b expected 1", busy8); end
        busy_cycles = 0; bad = 0;
        for (int c = 0; c < 300 && busy8 === 1'b1; c++) begin
            if (dvalid8 !== 1'b0 || dinrdy8 !== 1'b0) bad++;
            busy_cycles++;
            tick();
        end
        n_cmp++; if (busy_cycles != 144) begin n_err++; $display("[TB] FAIL busy_cycles: got %0d expected 144", busy_cycles); end
        n_cmp++; if (bad != 0) begin n_err++; $display("[TB] FAIL output_during_init: got %0d cycles expected 0", bad); end
        n_cmp++; if (dinrdy8 !== 1'b1) begin n_err++; $display("[TB] FAIL ready_after_init: got %b expected 1", dinrdy8); end
        for (int i = 0; i < 4; i++) begin
            din8 = 8'h00; dval8 = 1'b1;
            tick();
            n_cmp++;
            if ({dvalid8, dout8} !== {1'b1, ks_a[8*i +: 8]}) begin
                n_err++; $display("[TB] FAIL zero_key_word%0d: got %b/%h expected 1/%h", i, dvalid8, dout8, ks_a[8*i +: 8]);
            end
        end
        dval8 = 1'b0;
        tick();
    endtask

    task automatic test_width_equiv();
        logic [511:0] w8_bits, w1_bits;
        int bad;
        model_run(KEY_A, 80'h0, ks_a);
        do_load8(KEY_A, 80'h0);
        n_cmp++; if (dinrdy8 !== 1'b1) begin n_err++; $display("[TB] FAIL w8_ready: got %b expected 1", dinrdy8); end
        din8 = 8'h00; dval8 = 1'b1; doutrdy8 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            w8_bits[8*i +: 8] = dout8;
            n_cmp++;
            if ({dvalid8, dout8} !== {1'b1, ks_a[8*i +: 8]}) begin
                n_err++; $display("[TB] FAIL w8_word%0d: got %b/%h expected 1/%h", i, dvalid8, dout8, ks_a[8*i +: 8]);
            end
        end
        dval8 = 1'b0;
        tick();
        load1 = 1'b1;
        tick();
        load1 = 1'b0;
        repeat (1152) tick();
        n_cmp++; if (dinrdy1 !== 1'b1) begin n_err++; $display("[TB] FAIL w1_ready: got %b expected 1", dinrdy1); end
        din1 = 1'b0; dval1 = 1'b1; doutrdy1 = 1'b1; bad = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            w1_bits[i] = dout1[0];
            if (dvalid1 !== 1'b1) bad++;
        end
        dval1 = 1'b0;
        tick();
        n_cmp++; if (bad != 0) begin n_err++; $display("[TB] FAIL w1_valid: got %0d idle cycles expected 0", bad); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (w1_bits[8*i +: 8] !== ks_a[8*i +: 8]) begin
                n_err++; $display("[TB] FAIL w1_byte%0d: got %h expected %h", i, w1_bits[8*i +: 8], ks_a[8*i +: 8]);
            end
        end
        n_cmp++; if (w8_bits !== w1_bits) begin n_err++; $display("[TB] FAIL w8_vs_w1: streams differ, first words %h vs %h", w8_bits[63:0], w1_bits[63:0]); end
    endtask

    task automatic test_round_trip();
        logic [7:0] ct [256];
        model_run(KEY_A, IV_R, ks_b);
        do_load8(KEY_A, IV_R);
        n_cmp++; if (dinrdy8 !== 1'b1) begin n_err++; $display("[TB] FAIL rt_ready: got %b expected 1", dinrdy8); end
        doutrdy8 = 1'b1; dval8 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            din8 = 8'(i);
            tick();
            ct[i] = dout8;
            n_cmp++;
            if ({dvalid8, dout8} !== {1'b1, 8'(i) ^ ks_b[8*i +: 8]}) begin
                n_err++; $display("[TB] FAIL rt_cipher%0d: got %b/%h expected 1/%h", i, dvalid8, dout8, 8'(i) ^ ks_b[8*i +: 8]);
            end
        end
        dval8 = 1'b0;
        tick();
        do_load8(KEY_A, IV_R);
        dval8 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            din8 = ct[i];
            tick();
            n_cmp++;
            if ({dvalid8, dout8} !== {1'b1, 8'(i)}) begin
                n_err++; $display("[TB] FAIL rt_plain%0d: got %b/%h expected 1/%h", i, dvalid8, dout8, 8'(i));
            end
        end
        dval8 = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic       exp_valid, exp_hs;
        logic [7:0] exp_dout, cur_din;
        int sent, recv;
        model_run(KEY_B, IV_B, ks_b);
        do_load8(KEY_B, IV_B);
        exp_valid = 1'b0; exp_dout = '0; sent = 0; recv = 0;
        dval8 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            doutrdy8 = 1'($urandom_range(0, 1));
            cur_din  = 8'(sent * 29 + 7);
            din8     = cur_din;
            #1;
            exp_hs = !exp_valid || doutrdy8;
            n_cmp++;
            if (dinrdy8 !== exp_hs) begin n_err++; $display("[TB] FAIL bp_ready_c%0d: got %b expected %b", c, dinrdy8, exp_hs); end
            if (exp_valid && doutrdy8) recv++;
            tick();
            if (exp_hs) begin
                exp_dout  = cur_din ^ ks_b[8*sent +: 8];
                exp_valid = 1'b1;
                sent++;
            end else if (doutrdy8) begin
                exp_valid = 1'b0;
            end
            n_cmp++;
            if ({dvalid8, dout8} !== {exp_valid, exp_dout}) begin
                n_err++; $display("[TB] FAIL bp_out_c%0d: got %b/%h expected %b/%h", c, dvalid8, dout8, exp_valid, exp_dout);
            end
        end
        dval8 = 1'b0; doutrdy8 = 1'b1;
        if (exp_valid) recv++;
        tick();
        n_cmp++; if (dvalid8 !== 1'b0) begin n_err++; $display("[TB] FAIL bp_drain: got %b expected 0", dvalid8); end
        n_cmp++; if (recv != sent) begin n_err++; $display("[TB] FAIL bp_count: got %0d received expected %0d", recv, sent); end
    endtask

    task automatic test_exhaustion();
        model_run(KEY_C, 80'h0, ks_b);
        key = KEY_C; iv = '0;
        loadx = 1'b1;
        tick();
        loadx = 1'b0;
        repeat (144) tick();
        n_cmp++; if (dinrdyx !== 1'b1) begin n_err++; $display("[TB] FAIL ex_ready: got %b expected 1", dinrdyx); end
        doutrdyx = 1'b1; dvalx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dinx = 8'(i * 17);
            tick();
            n_cmp++;
            if (doutx !== (8'(i * 17) ^ ks_b[8*i +: 8])) begin
                n_err++; $display("[TB] FAIL ex_word%0d: got %h expected %h", i, doutx, 8'(i * 17) ^ ks_b[8*i +: 8]);
            end
            if (i == 2) begin
                n_cmp++; if (exhx !== 1'b0) begin n_err++; $display("[TB] FAIL ex_early: got %b expected 0", exhx); end
            end
        end
        n_cmp++; if ({exhx, dvalidx} !== 2'b11) begin n_err++; $display("[TB] FAIL ex_flag: got %b expected 11", {exhx, dvalidx}); end
        doutrdyx = 1'b0;
        #1;
        n_cmp++; if (dinrdyx !== 1'b0) begin n_err++; $display("[TB] FAIL ex_ready_low: got %b expected 0", dinrdyx); end
        repeat (3) tick();
        n_cmp++;
        if ({dvalidx, doutx} !== {1'b1, 8'(51) ^ ks_b[31:24]}) begin
            n_err++; $display("[TB] FAIL ex_hold: got %b/%h expected 1/%h", dvalidx, doutx, 8'(51) ^ ks_b[31:24]);
        end
        doutrdyx = 1'b1;
        tick();
        n_cmp++; if ({dvalidx, exhx, dinrdyx} !== 3'b010) begin n_err++; $display("[TB] FAIL ex_drained: got %b expected 010", {dvalidx, exhx, dinrdyx}); end
        dvalx = 1'b0;
        loadx = 1'b1;
        tick();
        loadx = 1'b0;
        n_cmp++; if ({exhx, busyx} !== 2'b01) begin n_err++; $display("[TB] FAIL ex_reload: got %b expected 01", {exhx, busyx}); end
    endtask

    task automatic test_load_mid_run();
        model_run(KEY_A, 80'h0, ks_a);
        model_run(KEY_B, IV_B, ks_b);
        do_load8(KEY_A, 80'h0);
        doutrdy8 = 1'b0; din8 = 8'h3C; dval8 = 1'b1;
        tick();
        dval8 = 1'b0;
        n_cmp++;
        if ({dvalid8, dout8} !== {1'b1, 8'h3C ^ ks_a[7:0]}) begin
            n_err++; $display("[TB] FAIL mid_first: got %b/%h expected 1/%h", dvalid8, dout8, 8'h3C ^ ks_a[7:0]);
        end
        tick();
        key = KEY_B; iv = IV_B; dval8 = 1'b1;
        load8 = 1'b1;
        tick();
        load8 = 1'b0; dval8 = 1'b0;
        n_cmp++; if ({dvalid8, busy8} !== 2'b01) begin n_err++; $display("[TB] FAIL mid_discard: got %b expected 01", {dvalid8, busy8}); end
        repeat (144) tick();
        n_cmp++; if (dinrdy8 !== 1'b1) begin n_err++; $display("[TB] FAIL mid_ready: got %b expected 1", dinrdy8); end
        doutrdy8 = 1'b1; din8 = 8'h00; dval8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({dvalid8, dout8} !== {1'b1, ks_b[8*i +: 8]}) begin
                n_err++; $display("[TB] FAIL mid_word%0d: got %b/%h expected 1/%h", i, dvalid8, dout8, ks_b[8*i +: 8]);
            end
        end
        dval8 = 1'b0;
    endtask

    task automatic test_reset_mid_init();
        key = KEY_A; iv = '0;
        load8 = 1'b1;
        tick();
        load8 = 1'b0;
        repeat (20) tick();
        n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("[TB] FAIL rmi_busy: got %b expected 1", busy8); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy8, dinrdy8, dvalid8, exh8, dout8} !== 12'h000) begin
            n_err++; $display("[TB] FAIL rmi_outputs: got %b/%b/%b/%b/%h expected 0/0/0/0/00", busy8, dinrdy8, dvalid8, exh8, dout8);
        end
        #1;
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++; if ({busy8, dinrdy8} !== 2'b00) begin n_err++; $display("[TB] FAIL rmi_idle: got %b expected 00", {busy8, dinrdy8}); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_warmup();
        test_width_equiv();
        test_round_trip();
        test_backpressure();
        test_exhaustion();
        test_load_mid_run();
        test_reset_mid_init();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trivium_stream_w.md
# trivium_stream_w

Parametrised Trivium stream-cipher core that generates W keystream bits per clock and XORs them onto a valid/ready data stream. It loads key and IV in parallel, runs the configurable warm-up, then encrypts or decrypts words with one-cycle latency. It enforces a per-key word limit, which forces a rekey. It replaces the byte-only, serial-key cipher block in the encryption datapath and sits between the input FIFO and the output FIFO.

## Interface
- W, 8: keystream/data bits per clock. Legal values are 1, 2, 4, 8, 16, 32, 64.
- INIT_ROUNDS, 1152: warm-up state updates. Must be a multiple of W.
- MAX_WORDS, 2**20: words accepted per key/IV before exhaustion. Must be ≥1.
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_in  in  80  key. key_in[0] is K1.
- iv_in  in  80  IV. iv_in[0] is IV1.
- load  in  1  one-cycle pulse. Captures key_in/iv_in and starts a new session.
- din  in  W  plaintext/ciphertext word.
- din_valid  in  1  din is valid.
- din_ready  out  1  core accepts din this cycle.
- dout  out  W  din XOR keystream.
- dout_valid  out  1  dout holds a result.
- dout_ready  in  1  downstream consumes dout.
- busy  out  1  high while in INIT.
- exhausted  out  1  MAX_WORDS reached; a new load is required.

## Operation
- **State s1..s288 at load:**
  - s1..s80 = K1..K80; s81..s93 = 0.
  - s94..s173 = IV1..IV80; s174..s177 = 0.
  - s178..s285 = 0; s286..s288 = 1.
- **One update step:**
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288; z = t1^t2^t3.
  - a1 = t1^(s91&s92)^s171, a2 = t2^(s175&s176)^s264, a3 = t3^(s286&s287)^s69.
  - Shift: (s1..s93) ← (a3, s1..s92); (s94..s177) ← (a1, s94..s176); (s178..s288) ← (a2, s178..s287).
- **Unrolled W steps per clock:** bit i of the word is the z of step i. dout[0] is the earliest keystream bit. Since W ≤ 64 < 66, all taps of one word are read from the registered state.
- **States:**
  - IDLE: after reset. din_ready=0.
  - INIT: INIT_ROUNDS/W cycles of W updates each, no output. Then go to RUN.
  - RUN: a handshake occurs when din_valid && din_ready. On a handshake:
    - dout ← din ^ z[W-1:0].
    - dout_valid ← 1.
    - the state advances W steps.
    - word_cnt increments.
  - RUN with no handshake: the cipher state is frozen.
  - EXHAUSTED: entered on the handshake that makes word_cnt == MAX_WORDS. Here din_ready=0 and exhausted=1. Any output still pending drains normally.
- **din_ready** = (state==RUN) && (!dout_valid || dout_ready) && !load.
- **dout_valid** clears on dout_ready with no new handshake in that cycle. dout stays stable while dout_valid && !dout_ready.
- **load** has priority in every state, including INIT, RUN and EXHAUSTED. On the next edge:
  - the cipher state is reloaded and the FSM enters INIT.
  - word_cnt = 0, exhausted = 0.
  - dout_valid = 0; any unconsumed output is discarded.
- **Counters:** the init counter is clog2(INIT_ROUNDS/W+1) bits; word_cnt is clog2(MAX_WORDS+1) bits. Neither wraps; both saturate at their terminal value.
- **Decryption** is the same operation as encryption. Driving din=0 yields raw keystream.

## Timing
- **Reset values:** state IDLE, cipher state all 0, din_ready=0, dout=0, dout_valid=0, busy=0, exhausted=0.
- load at edge n gives busy=1 from n+1 through n+INIT_ROUNDS/W. din_ready can first be 1 in cycle n+1+INIT_ROUNDS/W. For W=8 that is 144 busy cycles.
- Data latency is one cycle: a handshake at edge k gives dout_valid=1 after edge k.
- Full throughput is one word per clock while dout_ready=1.
- Simultaneous dout_ready and handshake: the output register is replaced by the new word and dout_valid stays 1.
- A reset assertion mid-operation immediately forces all reset values, independent of clk.

## Test plan
- **Warm-up count:** W=8, reset, then load key=0, iv=0 → busy high exactly 144 cycles; din_ready=1 on cycle 145; no dout_valid during INIT.
- **Width equivalence:**
  - Stimulus: W=1 and W=8 instances, key=80'h0123456789ABCDEF0123, iv=80'h0, din=0, 64 words on W=8.
  - Required: the W=8 bitstream (dout[0] first) equals the first 512 bits of the W=1 stream, and both equal the bit-serial software model of the update step above.
- **Round trip:** encrypt bytes 0x00..0xFF, then reload the same key/IV and feed the ciphertext → output is 0x00..0xFF in order.
- **Backpressure:**
  - Stimulus: random dout_ready at 50 %, din_valid always 1.
  - Required: dout is never changed while stalled; no word is lost or duplicated; the keystream position matches the stall-free run.
- **Exhaustion:**
  - Stimulus: MAX_WORDS=4.
  - Required: after the 4th handshake exhausted=1 and din_ready=0; the 4th output still drains.
  - Follow-up: load → exhausted=0 on the next cycle.
- **Load mid-run:**
  - Stimulus: pulse load while dout_valid=1 and dout_ready=0.
  - Required: dout_valid=0 on the next cycle, busy=1, and the stream restarts from the new key's first keystream bits.
  - Also: reset asserted mid-INIT returns every output to its reset value.
